// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative RV M-extension multiply/divide unit (shift-add multiply,
//            restoring divide) with valid/ready handshake and flush.
// Revision : 1.0
// ============================================================================
module mdu_iter #(
    parameter int XLEN    = 64,
    parameter int MUL_BPC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int              c_CW     = $clog2(XLEN) + 1;
    localparam logic [1:0]      c_IDLE   = 2'd0;
    localparam logic [1:0]      c_CALC   = 2'd1;
    localparam logic [1:0]      c_DONE   = 2'd2;
    localparam logic [c_CW-1:0] c_N_MUL  = c_CW'(XLEN / MUL_BPC);
    localparam logic [c_CW-1:0] c_N_MULW = c_CW'(32 / MUL_BPC);
    localparam logic [c_CW-1:0] c_N_DIV  = c_CW'(XLEN);
    localparam logic [c_CW-1:0] c_N_DIVW = c_CW'(32);
    localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);
    localparam logic [XLEN-1:0] c_MIN    = XLEN'(1) << (XLEN - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [2:0]        r_f3;
    logic              r_word;
    logic              r_neg;
    logic [c_CW-1:0]   r_cnt;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_opb;      // multiplier (shifted out) or divisor (held)
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_result;

    logic              w_word;
    logic              w_is_div;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic              w_sa;
    logic              w_sb;
    logic              w_neg;
    logic              w_dz;
    logic              w_ovf;
    logic              w_special;
    logic              w_accept;
    logic [c_CW-1:0]   w_n;
    logic [XLEN-1:0]   w_a_ext;
    logic [XLEN-1:0]   w_b_ext;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN-1:0]   w_spec_raw;
    logic [XLEN-1:0]   w_spec_res;

    logic [2*XLEN-1:0] w_pp;
    logic [2*XLEN-1:0] w_prod_nxt;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN:0]     w_trial;
    logic              w_qbit;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_res_raw;
    logic [XLEN-1:0]   w_res;

    // ---------------- request decode ----------------
    assign w_word   = (XLEN == 64) && is_word;
    assign w_is_div = funct3[2];
    assign w_a_sgn  = !(funct3[0] && (funct3[1] || funct3[2]));
    assign w_b_sgn  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);

    always_comb begin
        w_a_ext = src1;
        w_b_ext = src2;
        if (w_word) begin
            w_a_ext = w_a_sgn ? XLEN'($signed(src1[31:0])) : XLEN'(src1[31:0]);
            w_b_ext = w_b_sgn ? XLEN'($signed(src2[31:0])) : XLEN'(src2[31:0]);
        end
    end

    assign w_sa    = w_a_sgn && w_a_ext[XLEN-1];
    assign w_sb    = w_b_sgn && w_b_ext[XLEN-1];
    assign w_a_mag = w_sa ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_sb ? -w_b_ext : w_b_ext;
    assign w_neg   = (funct3[2] && funct3[1]) ? w_sa : (w_sa ^ w_sb);

    assign w_dz  = w_is_div && (w_b_ext == '0);
    assign w_ovf = w_is_div && !funct3[0] &&
                   (w_word ? ((src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF))
                           : ((src1 == c_MIN) && (src2 == '1)));
    assign w_special = w_dz || w_ovf;

    // REM family returns the dividend (or 0 on overflow); DIV family all ones (or dividend)
    assign w_spec_raw = funct3[1] ? (w_ovf ? '0 : src1) : (w_ovf ? src1 : '1);
    assign w_spec_res = w_word ? XLEN'($signed(w_spec_raw[31:0])) : w_spec_raw;

    assign w_n = w_is_div ? (w_word ? c_N_DIVW : c_N_DIV)
                          : (w_word ? c_N_MULW : c_N_MUL);

    assign in_ready  = (r_state == c_IDLE) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign result    = r_result;

    // ---------------- iteration datapath ----------------
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (r_opb[j]) begin
                w_pp = w_pp + (r_mcand << j);
            end
        end
    end

    assign w_prod_nxt = r_prod + w_pp;
    assign w_trial    = {r_rem, r_quo[XLEN-1]} - {1'b0, r_opb};
    assign w_qbit     = !w_trial[XLEN];
    assign w_rem_nxt  = w_qbit ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_quo_nxt  = {r_quo[XLEN-2:0], w_qbit};

    assign w_prod_fix = r_neg ? -w_prod_nxt : w_prod_nxt;
    assign w_quo_fix  = r_neg ? -w_quo_nxt  : w_quo_nxt;
    assign w_rem_fix  = r_neg ? -w_rem_nxt  : w_rem_nxt;

    always_comb begin
        w_res_raw = w_prod_fix[XLEN-1:0];
        case (r_f3)
            3'b000:                 w_res_raw = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_res_raw = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_res_raw = w_quo_fix;
            default:                w_res_raw = w_rem_fix;
        endcase
    end

    assign w_res = r_word ? XLEN'($signed(w_res_raw[31:0])) : w_res_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f3     <= '0;
            r_word   <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_opb    <= '0;
            r_prod   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (r_state == c_IDLE) begin
            if (w_accept) begin
                r_f3    <= funct3;
                r_word  <= w_word;
                r_neg   <= w_neg;
                r_cnt   <= w_n;
                r_mcand <= (2*XLEN)'(w_a_mag);
                r_opb   <= w_b_mag;
                r_prod  <= '0;
                r_rem   <= '0;
                // left-align the dividend so the restoring loop starts at its MSB
                r_quo   <= w_a_mag << (w_word ? (XLEN - 32) : 0);
                if (w_special) begin
                    r_result <= w_spec_res;
                end
            end
        end else if (r_state == c_CALC) begin
            r_cnt   <= r_cnt - c_ONE;
            r_mcand <= r_mcand << MUL_BPC;
            if (!r_f3[2]) begin
                r_opb <= r_opb >> MUL_BPC;
            end
            r_prod <= w_prod_nxt;
            r_quo  <= w_quo_nxt;
            r_rem  <= w_rem_nxt;
            if ((r_cnt == c_ONE) && !flush) begin
                r_result <= w_res;
            end
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_special ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (flush) begin
                    w_state_next = c_IDLE;
                end else if (r_cnt == c_ONE) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                if (flush || out_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Directed self-checking bench for mdu_iter (XLEN=64, MUL_BPC=2).
// Revision : 1.0
// ============================================================================
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic        is_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(64), .MUL_BPC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .is_word   (is_word),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // Issue one request from IDLE and wait (bounded) for out_valid; result stays in DONE.
    task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
        funct3 = f3; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL timeout f3=%b word=%b: out_valid=%b, required 1", f3, w, out_valid);
            lat = -1;
        end
        res = result;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
        total++; if (result !== 64'h0) begin bad++; $display("FAIL reset_result: got %h, want 0", result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [63:0] r; int lat;
        do_op(3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, r, lat);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mul_res: got %h, want ffffffffffffffeb", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency: got %0d, want 33", lat); end
        consume();
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mul_return_idle: busy=%b in_ready=%b, want 0/1", busy, in_ready); end
    endtask

    task automatic test_mulh();
        logic [63:0] r; int lat;
        do_op(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, r, lat);
        total++; if (r !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL mulh_res: got %h, want 4000000000000000", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL mulh_latency: got %0d, want 33", lat); end
        consume();
        do_op(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL mulhsu_res: got %h, want ffffffffffffffff", r); end
        consume();
        do_op(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL mulhu_res: got %h, want fffffffffffffffe", r); end
        consume();
    endtask

    task automatic test_div();
        logic [63:0] r; int lat;
        do_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, lat);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_res: got %h, want fffffffffffffffd", r); end
        total++; if (lat !== 65) begin bad++; $display("FAIL div_latency: got %0d, want 65", lat); end
        consume();
        do_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, lat);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rem_res: got %h, want ffffffffffffffff", r); end
        consume();
        do_op(3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat);
        total++; if (r !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL divu_res: got %h, want 7fffffffffffffff", r); end
        consume();
    endtask

    task automatic test_special();
        logic [2:0]  f3[6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [63:0] a[6]  = '{64'd5, 64'd5, 64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] b[6]  = '{64'd0, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] e[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5,
                               64'h8000_0000_0000_0000, 64'd0};
        logic [63:0] r; int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(f3[i], 1'b0, a[i], b[i], r, lat);
            total++; if (r !== e[i]) begin bad++; $display("FAIL special_res[%0d]: got %h, want %h", i, r, e[i]); end
            total++; if (lat !== 1) begin bad++; $display("FAIL special_latency[%0d]: got %0d, want 1", i, lat); end
            consume();
        end
    endtask

    task automatic test_word();
        logic [63:0] r; int lat;
        do_op(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, r, lat);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL divuw_res: got %h, want fffffffffffffffe", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL divuw_latency: got %0d, want 33", lat); end
        consume();
        do_op(3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, r, lat);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL mulw_res: got %h, want fffffffffffffffe", r); end
        total++; if (lat !== 17) begin bad++; $display("FAIL mulw_latency: got %0d, want 17", lat); end
        consume();
        do_op(3'b100, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, r, lat);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL divw_zero_res: got %h, want ffffffffffffffff", r); end
        total++; if (lat !== 1) begin bad++; $display("FAIL divw_zero_latency: got %0d, want 1", lat); end
        consume();
        do_op(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, r, lat);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL divw_res: got %h, want fffffffffffffffd", r); end
        consume();
    endtask

    task automatic test_hold();
        logic [63:0] r; int lat;
        do_op(3'b000, 1'b0, 64'd6, 64'd7, r, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (result !== 64'd42 || out_valid !== 1'b1) begin bad++; $display("FAIL hold_result[%0d]: got %h/%b, want 2a/1", i, result, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d]: got %b, want 0", i, in_ready); end
        end
        consume();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_flush();
        logic [63:0] r; int lat; bit seen;
        funct3 = 3'b100; is_word = 1'b0; src1 = 64'd100; src2 = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b, want 1", busy); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_idle: busy=%b out_valid=%b, want 0/0", busy, out_valid); end
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_result: out_valid seen=%b, want 0", seen); end
        do_op(3'b000, 1'b0, 64'd3, 64'd4, r, lat);
        total++; if (r !== 64'd12) begin bad++; $display("FAIL flush_recover: got %h, want c", r); end
        consume();
    endtask

    task automatic test_flush_accept();
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; is_word = 1'b0; src1 = 64'd2; src2 = 64'd2;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_mask_in_ready: got %b, want 0", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_accept: busy=%b out_valid=%b, want 0/0", busy, out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; int lat;
        funct3 = 3'b100; is_word = 1'b0; src1 = 64'd100; src2 = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_state: out_valid=%b busy=%b, want 0/0", out_valid, busy); end
        total++; if (result !== 64'h0) begin bad++; $display("FAIL rstmid_result: got %h, want 0", result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b, want 1", in_ready); end
        do_op(3'b101, 1'b0, 64'd100, 64'd3, r, lat);
        total++; if (r !== 64'd33) begin bad++; $display("FAIL rstmid_divu: got %h, want 21", r); end
        consume();
        do_op(3'b111, 1'b0, 64'd100, 64'd3, r, lat);
        total++; if (r !== 64'd1) begin bad++; $display("FAIL rstmid_remu: got %h, want 1", r); end
        consume();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; funct3 = 3'b000; is_word = 1'b0;
        src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_word();
        test_hold();
        test_flush();
        test_flush_accept();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
